// File: rtl/led_vu_meter.sv
`default_nettype none
// ============================================================================
// Module   : led_vu_meter
// Purpose  : Multi-channel LED level meter. Each channel turns signed audio
//            samples into a thermometer level with peak-hold, timed decay
//            and a bar/dot display mode.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module led_vu_meter #(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 2,
  parameter int LEDS_PER_CH = 4,
  parameter int STEP        = 3,
  parameter int HOLD_SAMP   = 4096,
  parameter int DECAY_SAMP  = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vld,
  input  logic [NUM_CH*DATA_W-1:0]      aud_in,
  input  logic                          mode,
  output logic [NUM_CH*LEDS_PER_CH-1:0] LED
);

  localparam int L       = LEDS_PER_CH;
  localparam int LVL_W   = $clog2(L + 1);
  localparam int CNT_MAX = (HOLD_SAMP > DECAY_SAMP) ? HOLD_SAMP : DECAY_SAMP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int MAG_W   = DATA_W - 1;

  localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(HOLD_SAMP - 1);
  localparam logic [CNT_W-1:0] DECAY_RELOAD = CNT_W'(DECAY_SAMP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE      = LVL_W'(1);
  localparam logic [MAG_W-1:0] MAG_ONE      = MAG_W'(1);
  localparam logic [MAG_W-1:0] MAG_MAX      = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DECAY = 2'd2;

  // Threshold for segment k: a single power of two, spaced STEP octaves apart
  // with the top segment STEP octaves below full scale.
  function automatic logic [MAG_W-1:0] thr(input int k);
    logic [MAG_W-1:0] t;
    t = '0;
    t[MAG_W - (L - k) * STEP] = 1'b1;
    return t;
  endfunction

  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] sample;
    logic [MAG_W-1:0]  mag;
    logic [LVL_W-1:0]  seg_n;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [LVL_W-1:0]  lvl;
    logic [LVL_W-1:0]  lvl_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [L-1:0]      led_nxt;
    logic [L-1:0]      led_q;

    assign sample = aud_in[c*DATA_W +: DATA_W];

    // Magnitude of the sample; the most negative code saturates to full scale
    always_comb begin
      mag = sample[MAG_W-1:0];
      if (sample[DATA_W-1]) begin
        if (sample[MAG_W-1:0] == '0) begin
          mag = MAG_MAX;
        end else begin
          mag = (~sample[MAG_W-1:0]) + MAG_ONE;
        end
      end
    end

    // Thermometer count of thresholds reached by the magnitude
    always_comb begin
      seg_n = '0;
      for (int k = 0; k < L; k++) begin
        if (mag >= thr(k)) begin
          seg_n = seg_n + LVL_ONE;
        end
      end
    end

    // Next-state logic: peak capture, hold countdown, then one-step decay
    always_comb begin
      state_nxt = state;
      lvl_nxt   = lvl;
      cnt_nxt   = cnt;
      if (vld) begin
        if ((seg_n >= lvl) && (seg_n != '0)) begin
          // A new or equal peak always (re)starts a full hold.
          lvl_nxt   = seg_n;
          cnt_nxt   = HOLD_RELOAD;
          state_nxt = S_HOLD;
        end else if ((seg_n == '0) && (lvl == '0)) begin
          state_nxt = S_IDLE;
        end else if (state == S_HOLD) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
          end else begin
            state_nxt = S_DECAY;
            cnt_nxt   = DECAY_RELOAD;
          end
        end else if (state == S_DECAY) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
          end else begin
            lvl_nxt = lvl - LVL_ONE;
            cnt_nxt = DECAY_RELOAD;
            if (lvl == LVL_ONE) begin
              state_nxt = S_IDLE;
            end
          end
        end
      end
    end

    // Display encoding of the upcoming level: bar fills up to it, dot marks it
    always_comb begin
      led_nxt = '0;
      for (int k = 0; k < L; k++) begin
        if (mode) begin
          led_nxt[k] = (lvl_nxt == LVL_W'(k + 1));
        end else begin
          led_nxt[k] = (lvl_nxt > LVL_W'(k));
        end
      end
    end

    // State, level, counter and LED registers with synchronous reset
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state <= S_IDLE;
        lvl   <= '0;
        cnt   <= '0;
        led_q <= '0;
      end else begin
        state <= state_nxt;
        lvl   <= lvl_nxt;
        cnt   <= cnt_nxt;
        led_q <= led_nxt;
      end
    end

    assign LED[c*L +: L] = led_q;
  end

endmodule
`default_nettype wire
